// File: rtl/keypad.sv
// 4x4 active-low key-matrix scanner on the CPU read bus (0xf8-0xfb).
// One row is driven per time slot, each row is debounced by comparing two consecutive samples, and the latest press code is latched.
module keypad #(
  parameter int unsigned SCAN_BITS = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       re,
  input  logic [7:0] addr,
  output logic [7:0] out,
  output logic [3:0] row,
  input  logic [3:0] col
);

  localparam int unsigned CW = SCAN_BITS + 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    prev_q [4];
  logic [3:0]    prev_d [4];
  logic [15:0]   stable_q, stable_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic [4:0]    pcnt_q, pcnt_d;
  logic [7:0]    out_q, out_d;

  logic [1:0]    r;
  logic [3:0]    cur;
  logic [3:0]    new_keys;
  logic [1:0]    low_idx;
  logic          sample;
  logic          rd_status;

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    // Row register follows the counter's next value so it always matches the current slot.
    row_d     = ~(4'b0001 << cnt_d[CW-1 -: 2]);
    r         = cnt_q[CW-1 -: 2];
    cur       = ~sync2_q;
    sample    = &cnt_q[SCAN_BITS-1:0];
    rd_status = re && (addr == 8'hf8);

    prev_d    = prev_q;
    stable_d  = stable_q;
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    new_keys  = '0;
    low_idx   = '0;

    if (rd_status) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (sample) begin
      prev_d[r] = cur;
      if (cur == prev_q[r]) begin
        new_keys                   = cur & ~stable_q[{r, 2'b00} +: 4];
        stable_d[{r, 2'b00} +: 4]  = cur;
      end
    end

    for (int unsigned i = 4; i > 0; i--) begin
      if (new_keys[i-1]) low_idx = 2'(i - 1);
    end

    // A press in the same cycle as a status read wins; overrun only accrues without a read.
    if (|new_keys) begin
      valid_d   = 1'b1;
      overrun_d = rd_status ? 1'b0 : (overrun_q | valid_q);
      code_d    = {r, low_idx};
    end

    pcnt_d = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      pcnt_d = pcnt_d + {4'b0000, stable_q[i]};
    end

    out_d = '0;
    if (re) begin
      unique case (addr)
        8'hf8:   out_d = {valid_q, overrun_q, 2'b00, code_q};
        8'hf9:   out_d = stable_q[7:0];
        8'hfa:   out_d = stable_q[15:8];
        8'hfb:   out_d = {3'b000, pcnt_q};
        default: out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      row_q     <= 4'b1110;
      sync1_q   <= '1;
      sync2_q   <= '1;
      for (int unsigned i = 0; i < 4; i++) prev_q[i] <= '0;
      stable_q  <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      pcnt_q    <= '0;
      out_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      sync1_q   <= col;
      sync2_q   <= sync1_q;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      pcnt_q    <= pcnt_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;
  assign row = row_q;

endmodule

// File: tb/tb_keypad.sv
// Bench for keypad: a matrix model drives col from held keys, a cycle model predicts out/row,
// and directed reads pin the scenarios with literal values.
module tb_keypad;

  localparam int SB    = 2;
  localparam int SLOT  = 1 << SB;
  localparam int SWEEP = 4 * SLOT;

  logic       clk;
  logic       rst_n;
  logic       re;
  logic [7:0] addr;
  logic [7:0] out;
  logic [3:0] row;
  logic [3:0] col;
  logic [15:0] held;

  int n_cmp;
  int n_err;

  keypad #(.SCAN_BITS(SB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (re),
    .addr  (addr),
    .out   (out),
    .row   (row),
    .col   (col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hf;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (!row[rr] && held[4*rr+cc]) col[cc] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  int          m_cnt;
  logic [3:0]  m_row;
  logic [3:0]  m_seen [2];
  logic [3:0]  m_prev [4];
  logic [15:0] m_stable;
  logic [3:0]  m_code;
  logic        m_valid;
  logic        m_ovr;
  logic [4:0]  m_pcnt;
  logic [7:0]  m_out;

  function automatic logic [3:0] matrix_cols(input logic [15:0] h, input int rr);
    logic [3:0] c;
    c = 4'hf;
    for (int cc = 0; cc < 4; cc++) if (h[4*rr+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_row = 4'b1110;
    m_seen[0] = 4'hf;
    m_seen[1] = 4'hf;
    for (int i = 0; i < 4; i++) m_prev[i] = 4'h0;
    m_stable = '0;
    m_code = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_pcnt = '0;
    m_out = '0;
  endtask

  task automatic model_step();
    int          rr;
    logic [3:0]  cur;
    logic [3:0]  nw;
    logic        rd;
    logic [7:0]  o;
    logic [15:0] st_old;
    rr     = m_cnt / SLOT;
    cur    = ~m_seen[1];
    rd     = re && (addr == 8'hf8);
    st_old = m_stable;
    o = 8'h00;
    if (re) begin
      case (addr)
        8'hf8:   o = {m_valid, m_ovr, 2'b00, m_code};
        8'hf9:   o = m_stable[7:0];
        8'hfa:   o = m_stable[15:8];
        8'hfb:   o = {3'b000, m_pcnt};
        default: o = 8'h00;
      endcase
    end
    m_out = o;
    nw = 4'h0;
    if (m_cnt % SLOT == SLOT - 1) begin
      if (cur == m_prev[rr]) begin
        nw = cur & ~m_stable[4*rr +: 4];
        m_stable[4*rr +: 4] = cur;
      end
      m_prev[rr] = cur;
    end
    if (nw != 0) begin
      m_ovr   = rd ? 1'b0 : (m_ovr | m_valid);
      m_valid = 1'b1;
      for (int cc = 3; cc >= 0; cc--) if (nw[cc]) m_code = 4'(4 * rr + cc);
    end else if (rd) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    m_pcnt = 5'($countones(st_old));
    m_seen[1] = m_seen[0];
    m_seen[0] = matrix_cols(held, rr);
    m_cnt = (m_cnt + 1) % SWEEP;
    m_row = 4'b1111 ^ (4'b0001 << (m_cnt / SLOT));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_cycle", out, m_out);
      chk("row_cycle", {4'h0, row}, {4'h0, m_row});
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string nm);
    @(negedge clk);
    re = 1'b1;
    addr = a;
    @(negedge clk);
    re = 1'b0;
    addr = 8'h00;
    chk(nm, out, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt(input int v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * SWEEP; i++) begin
      @(negedge clk);
      if (m_cnt == v) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("wait_cnt_timeout", 8'h00, 8'h01);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    held = '0;
    re = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    re = 1'b0;
    addr = 8'h00;
    held = '0;
    wait_cyc(3);
    #2 rst_n = 1'b1;

    rd_chk(8'hf8, 8'h00, "rst_f8");
    rd_chk(8'hf9, 8'h00, "rst_f9");
    rd_chk(8'hfa, 8'h00, "rst_fa");
    rd_chk(8'hfb, 8'h00, "rst_fb");

    // Single press of key 6
    held = 16'h0040;
    wait_cyc(3 * SWEEP);
    rd_chk(8'hf8, 8'h86, "press_f8");
    rd_chk(8'hf8, 8'h06, "press_f8_cleared");
    rd_chk(8'hf9, 8'h40, "press_f9");
    rd_chk(8'hfb, 8'h01, "press_fb");
    held = '0;
    wait_cyc(2 * SWEEP + 2);
    rd_chk(8'hf9, 8'h00, "release_f9");
    rd_chk(8'hf8, 8'h06, "release_no_event");

    // Asynchronous reset mid-sweep while out holds a nonzero value
    wait_cnt(9);
    re = 1'b1;
    addr = 8'hf8;
    @(negedge clk);
    re = 1'b0;
    addr = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_row", {4'h0, row}, 8'h0e);
    chk("rst_async_out", out, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rd_chk(8'hf8, 8'h00, "rst_async_f8");

    // Bounce: key 6 held across only one row-1 sample
    do_reset();
    held = 16'h0040;
    wait_cyc(10);
    held = '0;
    wait_cyc(3 * SWEEP);
    rd_chk(8'hf8, 8'h00, "bounce_f8");
    rd_chk(8'hf9, 8'h00, "bounce_f9");

    // Overrun: key 1 then key 14, no reads in between
    do_reset();
    held = 16'h0002;
    wait_cyc(3 * SWEEP);
    held = 16'h4002;
    wait_cyc(3 * SWEEP);
    rd_chk(8'hf8, 8'hce, "ovr_f8");
    rd_chk(8'hfa, 8'h40, "ovr_fa");
    rd_chk(8'hfb, 8'h02, "ovr_fb");
    rd_chk(8'hf8, 8'h0e, "ovr_f8_cleared");

    // Same-row priority: keys 8 and 11
    do_reset();
    held = 16'h0900;
    wait_cyc(3 * SWEEP);
    rd_chk(8'hf8, 8'h88, "prio_f8");
    rd_chk(8'hfa, 8'h09, "prio_fa");

    // Read/event collision on key 3 while key 0's event is still pending
    do_reset();
    held = 16'h0001;
    wait_cyc(3 * SWEEP);
    wait_cnt(0);
    held = 16'h0009;
    wait_cnt(SLOT - 1);
    wait_cnt(SLOT - 1);
    re = 1'b1;
    addr = 8'hf8;
    @(negedge clk);
    re = 1'b0;
    addr = 8'h00;
    chk("collide_preclear", out, 8'h80);
    rd_chk(8'hf8, 8'h83, "collide_f8");
    rd_chk(8'h10, 8'h00, "unmapped");
    addr = 8'hf8;
    @(negedge clk);
    chk("re_idle", out, 8'h00);
    addr = 8'h00;

    // Randomized holds and reads, checked by the per-cycle model compare
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0)
        held = 16'(1 << $urandom_range(0, 15)) |
               (($urandom_range(0, 2) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000);
      else if ($urandom_range(0, 39) == 0)
        held = '0;
      re = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: addr = 8'hf8;
        1: addr = 8'hf9;
        2: addr = 8'hfa;
        3: addr = 8'hfb;
        default: addr = 8'($urandom);
      endcase
    end
    re = 1'b0;
    wait_cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
